order_executed_with_price_encoder: RTL and testbench
====================================================

ORDER_EXECUTED_WITH_PRICE_ENCODER -- requirements
Module: order_executed_with_price_encoder

Interface
REQ-001 The block SHALL have no parameters; message length is fixed at 408 bits (51 bytes).
REQ-002 clk  input  1  single clock; all sequential logic on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle request to encode the field inputs; accepted only while busy=0.
REQ-005 trackerIn  input  6  bit offset in the first output word where the message begins; only 0,8,...,56 are legal, and bits [2:0] SHALL be ignored.
REQ-006 timeStamp 32, orderID 64, orderBookID 32, side 8, executedQuantity 64, matchID 64, comboGroupID 32, reservedOne 32, reservedTwo 32, tradePrice 32, occuredAtCross 8, printable 8  inputs  message fields, sampled on start acceptance.
REQ-007 outReady  input  1  downstream accepts dataOut when outReady=1 and dataValid=1.
REQ-008 busy  output  1  high from the cycle after acceptance until the final word handshake completes.
REQ-009 dataOut  output  64  packed message word.
REQ-010 dataValid  output  1  dataOut holds a valid word.
REQ-011 byteKeep  output  8  per-lane valid mask for dataOut (bit i covers bits [8i+7:8i]).
REQ-012 last  output  1  marks the final word of the message; valid only with dataValid.
REQ-013 trackerOut  output  6  bits used in the final word, modulo 64; valid while last=1.

Function
REQ-014 Message vector M[407:0] SHALL equal {printable, occuredAtCross, tradePrice, reservedTwo, reservedOne, comboGroupID, matchID, executedQuantity, side, orderBookID, orderID, timeStamp}, and stream byte k SHALL be M[8k+7:8k].
REQ-015 With o=trackerIn[5:3], stream byte k SHALL appear in word index (o+k)/8, lane (o+k) mod 8.
REQ-016 Word count SHALL be 7 for o<=5 and 8 for o>=6.
REQ-017 Byte lanes not carrying message bytes SHALL be driven 0 in dataOut and 0 in byteKeep.
REQ-018 trackerOut SHALL equal (8*o + 24) mod 64; a value of 0 means the final word is full (byteKeep=8'hFF).
REQ-019 States SHALL be IDLE and SEND; a 3-bit word counter tracks the word index.
REQ-020 IDLE: start=1 SHALL latch all fields and o, set busy, and go to SEND; dataValid SHALL rise on the next cycle, giving word 0 one cycle after acceptance.
REQ-021 SEND: dataOut, byteKeep, last and trackerOut SHALL hold stable while dataValid=1 and outReady=0.
REQ-022 SEND: on the handshake of a non-final word, the counter SHALL advance and the next word SHALL be presented the following cycle without a gap.
REQ-023 SEND: on the handshake of the final word, the block SHALL return to IDLE with dataValid=0 and busy=0 on the next cycle.
REQ-024 start asserted while busy=1 SHALL be ignored; latched fields SHALL NOT change.
REQ-025 start asserted in the cycle of the final handshake SHALL be ignored; a new message needs start while busy=0.
REQ-026 Input field changes after acceptance SHALL NOT affect the emitted words.
REQ-027 Output registers SHALL drive dataOut, dataValid, byteKeep, last and trackerOut directly, with no combinational path from start or field inputs.

Reset
REQ-028 While rst=1, and immediately on its assertion, state SHALL be IDLE, the counter 0, and busy, dataValid and last 0; dataOut, byteKeep and trackerOut SHALL be 0.
REQ-029 rst asserted mid-message SHALL abort the message; after release no remaining words SHALL be emitted and the next start SHALL be encoded from word 0.

Verification
REQ-030 trackerIn=0, timeStamp=32'h11223344, orderID=64'h0102030405060708, outReady=1 -> 7 words; word0=64'h0506070811223344, keep=FF; word6 keep=8'h07, last=1, trackerOut=24.
REQ-031 trackerIn=40, all fields nonzero -> 7 words; word0 keep=8'hE0 carrying timeStamp bytes 0-2; word6 keep=FF, last=1, trackerOut=0.
REQ-032 trackerIn=48 -> 8 words; word0 keep=8'hC0; word7 keep=8'h01, last=1, trackerOut=8.
REQ-033 outReady toggled 1,0,0,1 pseudo-randomly through a message -> word sequence identical to the outReady=1 run; outputs stable during each stall.
REQ-034 start pulsed during word 3, and again in the final-handshake cycle -> both ignored; busy falls after the final word, with no second message.
REQ-035 rst pulsed asynchronously (between clock edges) during word 4 -> dataValid and busy 0 at once; a new start with trackerIn=0 produces a correct 7-word message.

Source files
------------

// File: rtl/order_executed_with_price_encoder.sv
// Order-executed message encoder: packs the 51-byte message into 64-bit words
// starting at a byte offset in the first word, streamed over a valid/ready port.
module order_executed_with_price_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  trackerIn,
    input  logic [31:0] timeStamp,
    input  logic [63:0] orderID,
    input  logic [31:0] orderBookID,
    input  logic [7:0]  side,
    input  logic [63:0] executedQuantity,
    input  logic [63:0] matchID,
    input  logic [31:0] comboGroupID,
    input  logic [31:0] reservedOne,
    input  logic [31:0] reservedTwo,
    input  logic [31:0] tradePrice,
    input  logic [7:0]  occuredAtCross,
    input  logic [7:0]  printable,
    input  logic        outReady,
    output logic        busy,
    output logic [63:0] dataOut,
    output logic        dataValid,
    output logic [7:0]  byteKeep,
    output logic        last,
    output logic [5:0]  trackerOut,
    output logic        state_dbg
);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t       state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [2:0]   last_idx_q, last_idx_d;
    logic [511:0] sh_q, sh_d;
    logic [63:0]  keep_q, keep_d;
    logic         valid_q, valid_d;
    logic         last_q, last_d;
    logic [5:0]   trk_q, trk_d;

    logic [407:0] msg;
    logic [2:0]   o_in;
    logic         hs;
    logic         unused_tracker_lsbs;

    assign msg = {printable, occuredAtCross, tradePrice, reservedTwo, reservedOne,
                  comboGroupID, matchID, executedQuantity, side, orderBookID,
                  orderID, timeStamp};
    assign o_in = trackerIn[5:3];
    assign unused_tracker_lsbs = ^trackerIn[2:0];

    // Handshake: a word transfers on a rising edge where dataValid=1 and
    // outReady=1; while dataValid=1 and outReady=0 every output holds.
    assign hs = valid_q && outReady;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_idx_d = last_idx_q;
        sh_d       = sh_q;
        keep_d     = keep_q;
        valid_d    = valid_q;
        last_d     = last_q;
        trk_d      = trk_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SEND;
                    // The whole message is pre-shifted into place; each word is
                    // then just the low 64 bits of a right-shifting register.
                    sh_d       = {104'b0, msg} << {o_in, 3'b000};
                    keep_d     = {13'b0, {51{1'b1}}} << o_in;
                    cnt_d      = 3'd0;
                    last_idx_d = (o_in >= 3'd6) ? 3'd7 : 3'd6;
                    valid_d    = 1'b1;
                    last_d     = 1'b0;
                    trk_d      = {o_in, 3'b000} + 6'd24;
                end
            end
            SEND: begin
                if (hs) begin
                    if (last_q) begin
                        state_d    = IDLE;
                        cnt_d      = 3'd0;
                        last_idx_d = 3'd0;
                        sh_d       = '0;
                        keep_d     = '0;
                        valid_d    = 1'b0;
                        last_d     = 1'b0;
                        trk_d      = '0;
                    end else begin
                        cnt_d  = cnt_q + 3'd1;
                        sh_d   = sh_q >> 64;
                        keep_d = keep_q >> 8;
                        last_d = ((cnt_q + 3'd1) == last_idx_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            last_idx_q <= 3'd0;
            sh_q       <= '0;
            keep_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            trk_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_idx_q <= last_idx_d;
            sh_q       <= sh_d;
            keep_q     <= keep_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            trk_q      <= trk_d;
        end
    end

    assign busy       = (state_q == SEND);
    assign state_dbg  = state_q;
    assign dataOut    = sh_q[63:0];
    assign byteKeep   = keep_q[7:0];
    assign dataValid  = valid_q;
    assign last       = last_q;
    assign trackerOut = trk_q;

endmodule

// File: tb/tb_order_executed_with_price_encoder.sv
// Directed bench for order_executed_with_price_encoder: hand-computed words plus
// a byte-placement model feeding an expected-word queue.
module tb_order_executed_with_price_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  tracker_in = '0;
  logic [31:0] time_stamp, order_book_id, combo_group_id, reserved_one, reserved_two, trade_price;
  logic [63:0] order_id, executed_quantity, match_id;
  logic [7:0]  side, occured_at_cross, printable;
  logic        out_ready = 1'b0;
  logic        busy, data_valid, last, state_dbg;
  logic [63:0] data_out;
  logic [7:0]  byte_keep;
  logic [5:0]  tracker_out;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] exp_q[$];
  logic [7:0]  keep_exp_q[$];
  int          exp_n;
  logic [5:0]  exp_trk;

  logic [63:0] got_data[8];
  logic [7:0]  got_keep[8];
  logic [5:0]  got_trk[8];
  logic [63:0] ref_data[8];
  int          got_n;
  int          ready_mode = 0;
  int          start_at_word = -1;
  bit          start_at_final = 1'b0;
  int          reset_at_word = -1;
  bit          aborted;

  order_executed_with_price_encoder dut (
    .clk(clk), .rst(rst), .start(start), .trackerIn(tracker_in),
    .timeStamp(time_stamp), .orderID(order_id), .orderBookID(order_book_id),
    .side(side), .executedQuantity(executed_quantity), .matchID(match_id),
    .comboGroupID(combo_group_id), .reservedOne(reserved_one),
    .reservedTwo(reserved_two), .tradePrice(trade_price),
    .occuredAtCross(occured_at_cross), .printable(printable),
    .outReady(out_ready), .busy(busy), .dataOut(data_out),
    .dataValid(data_valid), .byteKeep(byte_keep), .last(last),
    .trackerOut(tracker_out), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic set_fields_a();
    time_stamp        = 32'h11223344;
    order_id          = 64'h0102030405060708;
    order_book_id     = 32'hB1B2B3B4;
    side              = 8'hE7;
    executed_quantity = 64'h2122232425262728;
    match_id          = 64'h3132333435363738;
    combo_group_id    = 32'h41424344;
    reserved_one      = 32'h51525354;
    reserved_two      = 32'h91929394;
    trade_price       = 32'hA1A2A3A4;
    occured_at_cross  = 8'hC5;
    printable         = 8'hD6;
  endtask

  function automatic logic [407:0] build_m();
    return {printable, occured_at_cross, trade_price, reserved_two, reserved_one,
            combo_group_id, match_id, executed_quantity, side, order_book_id,
            order_id, time_stamp};
  endfunction

  // Model: lane L of word w carries stream byte (8w + L - o) when it lies in 0..50.
  task automatic load_expected(input int o);
    logic [407:0] m;
    logic [63:0]  w_data;
    logic [7:0]   w_keep;
    int           k;
    m = build_m();
    exp_q.delete();
    keep_exp_q.delete();
    exp_n = (51 + o + 7) / 8;
    exp_trk = 6'(((51 + o) % 8) * 8);
    for (int w = 0; w < exp_n; w++) begin
      w_data = '0;
      w_keep = '0;
      for (int l = 0; l < 8; l++) begin
        k = w * 8 + l - o;
        if (k >= 0 && k < 51) begin
          w_data[l*8 +: 8] = m[k*8 +: 8];
          w_keep[l] = 1'b1;
        end
      end
      exp_q.push_back(w_data);
      keep_exp_q.push_back(w_keep);
    end
  endtask

  task automatic run_msg(input logic [5:0] trk);
    int          cyc;
    bit          done, held, final_hs;
    logic [63:0] h_data, e_data;
    logic [7:0]  h_keep, e_keep;
    logic        h_last, e_last;
    logic [5:0]  h_trk;
    load_expected(int'(trk[5:3]));
    got_n = 0;
    aborted = 1'b0;
    @(negedge clk);
    tracker_in = trk;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (data_valid !== 1'b1 || busy !== 1'b1 || state_dbg !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_latency: valid=%b busy=%b state=%b, required 1 1 1", data_valid, busy, state_dbg);
    end
    done = 1'b0; held = 1'b0; final_hs = 1'b0; cyc = 0;
    while (!done && cyc < 400) begin
      start = 1'b0;
      out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (held) begin
        vectors++;
        if (data_out !== h_data || byte_keep !== h_keep || last !== h_last || tracker_out !== h_trk || data_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL stall_hold: data=%h keep=%h last=%b trk=%0d, required %h %h %b %0d",
                   data_out, byte_keep, last, tracker_out, h_data, h_keep, h_last, h_trk);
        end
      end
      if (reset_at_word == got_n && data_valid) begin
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (data_valid !== 1'b0 || busy !== 1'b0 || last !== 1'b0 || data_out !== 64'h0 || byte_keep !== 8'h0) begin
          miscompares++;
          $display("FAIL async_reset: valid=%b busy=%b last=%b data=%h keep=%h, required all 0",
                   data_valid, busy, last, data_out, byte_keep);
        end
        #1 rst = 1'b0;
        aborted = 1'b1;
        done = 1'b1;
        held = 1'b0;
      end else if (data_valid && out_ready) begin
        held = 1'b0;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL extra_word: word %0d data=%h, required no word", got_n, data_out);
          final_hs = 1'b1;
        end else begin
          e_data = exp_q.pop_front();
          e_keep = keep_exp_q.pop_front();
          e_last = (got_n == exp_n - 1);
          vectors++;
          if (data_out !== e_data || byte_keep !== e_keep || last !== e_last) begin
            miscompares++;
            $display("FAIL word%0d: data=%h keep=%h last=%b, required %h %h %b",
                     got_n, data_out, byte_keep, last, e_data, e_keep, e_last);
          end
          if (e_last) begin
            vectors++;
            if (tracker_out !== exp_trk) begin
              miscompares++;
              $display("FAIL tracker_out: got %0d, required %0d", tracker_out, exp_trk);
            end
          end
          if (got_n < 8) begin
            got_data[got_n] = data_out;
            got_keep[got_n] = byte_keep;
            got_trk[got_n]  = tracker_out;
          end
          if (got_n == start_at_word) begin
            start = 1'b1;
            time_stamp = ~time_stamp;
            order_id = ~order_id;
            printable = ~printable;
            tracker_in = 6'd48;
          end
          if (last) begin
            final_hs = 1'b1;
            if (start_at_final) start = 1'b1;
          end
          got_n++;
        end
      end else begin
        held = data_valid;
        h_data = data_out; h_keep = byte_keep; h_last = last; h_trk = tracker_out;
      end
      @(negedge clk);
      cyc++;
      if (final_hs) done = 1'b1;
    end
    start = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: %0d words after %0d cycles, required %0d words", got_n, cyc, exp_n);
    end else if (!aborted) begin
      vectors++;
      if (got_n !== exp_n || data_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL msg_end: words=%0d valid=%b busy=%b, required %0d 0 0", got_n, data_valid, busy, exp_n);
      end
    end
  endtask

  task automatic check_idle(input int cycles, input string name);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      vectors++;
      if (data_valid !== 1'b0 || busy !== 1'b0 || state_dbg !== 1'b0) begin
        miscompares++;
        $display("FAIL %s: valid=%b busy=%b state=%b, required 0 0 0", name, data_valid, busy, state_dbg);
      end
    end
  endtask

  task automatic test_reset();
    set_fields_a();
    rst = 1'b1;
    start = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (data_valid !== 1'b0 || busy !== 1'b0 || last !== 1'b0 || data_out !== 64'h0 ||
        byte_keep !== 8'h0 || tracker_out !== 6'd0 || state_dbg !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b busy=%b last=%b data=%h keep=%h trk=%0d, required all 0",
               data_valid, busy, last, data_out, byte_keep, tracker_out);
    end
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_offset0();
    set_fields_a();
    ready_mode = 0;
    run_msg(6'd0);
    vectors++;
    if (got_data[0] !== 64'h0506070811223344 || got_keep[0] !== 8'hFF) begin
      miscompares++;
      $display("FAIL off0_word0: %h/%h, required 0506070811223344/ff", got_data[0], got_keep[0]);
    end
    vectors++;
    if (got_data[1] !== 64'hB1B2B3B401020304) begin
      miscompares++;
      $display("FAIL off0_word1: %h, required b1b2b3b401020304", got_data[1]);
    end
    vectors++;
    if (got_data[6] !== 64'h0000000000D6C5A1 || got_keep[6] !== 8'h07 || got_trk[6] !== 6'd24) begin
      miscompares++;
      $display("FAIL off0_word6: %h/%h/%0d, required d6c5a1/07/24", got_data[6], got_keep[6], got_trk[6]);
    end
  endtask

  task automatic test_offset40();
    set_fields_a();
    run_msg(6'd40);
    vectors++;
    if (got_data[0] !== 64'h2233440000000000 || got_keep[0] !== 8'hE0) begin
      miscompares++;
      $display("FAIL off40_word0: %h/%h, required 2233440000000000/e0", got_data[0], got_keep[0]);
    end
    vectors++;
    if (got_data[6] !== 64'hD6C5A1A2A3A49192 || got_keep[6] !== 8'hFF || got_trk[6] !== 6'd0) begin
      miscompares++;
      $display("FAIL off40_word6: %h/%h/%0d, required d6c5a1a2a3a49192/ff/0", got_data[6], got_keep[6], got_trk[6]);
    end
  endtask

  task automatic test_offset48();
    set_fields_a();
    run_msg(6'd53);  // low bits 101 must be ignored: behaves as 48
    vectors++;
    if (got_data[0] !== 64'h3344000000000000 || got_keep[0] !== 8'hC0) begin
      miscompares++;
      $display("FAIL off48_word0: %h/%h, required 3344000000000000/c0", got_data[0], got_keep[0]);
    end
    vectors++;
    if (got_data[7] !== 64'h00000000000000D6 || got_keep[7] !== 8'h01 || got_trk[7] !== 6'd8) begin
      miscompares++;
      $display("FAIL off48_word7: %h/%h/%0d, required d6/01/8", got_data[7], got_keep[7], got_trk[7]);
    end
  endtask

  task automatic test_stall();
    set_fields_a();
    ready_mode = 0;
    run_msg(6'd16);
    for (int i = 0; i < 8; i++) ref_data[i] = got_data[i];
    ready_mode = 1;
    run_msg(6'd16);
    ready_mode = 0;
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (got_data[i] !== ref_data[i]) begin
        miscompares++;
        $display("FAIL stall_seq word%0d: %h, required %h", i, got_data[i], ref_data[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    set_fields_a();
    start_at_word = 3;
    start_at_final = 1'b1;
    run_msg(6'd8);
    start_at_word = -1;
    start_at_final = 1'b0;
    check_idle(4, "no_second_msg");
  endtask

  task automatic test_async_reset();
    set_fields_a();
    reset_at_word = 4;
    run_msg(6'd24);
    reset_at_word = -1;
    check_idle(3, "abort_no_words");
    set_fields_a();
    run_msg(6'd0);
    vectors++;
    if (got_data[0] !== 64'h0506070811223344 || got_data[6] !== 64'h0000000000D6C5A1) begin
      miscompares++;
      $display("FAIL post_reset_msg: w0=%h w6=%h, required 0506070811223344 d6c5a1", got_data[0], got_data[6]);
    end
  endtask

  initial begin
    test_reset();
    test_offset0();
    test_offset40();
    test_offset48();
    test_stall();
    test_start_ignored();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
